serial_tx_fifo: RTL

- Parametrised successor to the current write-only debug serial peripheral.
- Memory-mapped UART transmitter: a CPU store to the data register pushes a byte into a transmit FIFO.
- An FSM shifts each byte out on `tx` as 8N1 (optionally with even parity) at a runtime-programmable baud divisor.
- Sits on the data-memory bus behind the Mmu select line (`sel_serial`) and is clocked by the data-memory write clock. It also adds status and divisor registers for software polling.

---
 rtl/serial_tx_fifo_if.sv | 11 +
 rtl/serial_tx_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_fifo_if.sv
// Register bus between the data-memory side and the serial transmitter.
interface serial_tx_fifo_if;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output sel, output we, output addr, output din, input dout);
  modport slave  (input sel, input we, input addr, input din, output dout);
endinterface

// File: rtl/serial_tx_fifo.sv
// Memory-mapped UART transmitter with a transmit FIFO, STATUS and DIV registers.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_tx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic             clock,
  input  logic             reset,
  serial_tx_fifo_if.slave  bus,
  output logic             tx,
  output logic             irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [15:0]      DIV_RST  = 16'(CLK_DIV);
`ifdef SERIAL_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [15:0]          div_reg, frame_div_reg;
  logic [15:0]          timer_reg, timer_next;
  logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 overflow_reg;
  logic                 tx_reg, tx_next;
  state_t               state_reg, state_next;
  logic                 shift_en, bit_done;
`ifdef SERIAL_TX_PARITY_EN
  logic                 parity_reg;
`endif

  logic [1:0]  reg_sel;
  logic        wr_en, data_wr, full, empty, push, pop;
  logic [31:0] status;
  logic        unused_bits;

  assign reg_sel     = bus.addr[3:2];
  assign wr_en       = bus.sel & bus.we;
  assign data_wr     = wr_en & (reg_sel == 2'd0);
  assign full        = (count_reg == FULL_CNT);
  assign empty       = (count_reg == '0);
  // Full is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
  assign push        = data_wr & ~full;
  assign pop         = (state_reg == S_IDLE) & ~empty;
  assign bit_done    = (timer_reg == 16'd0);
  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.din[31:16]};

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= bus.din[DATA_BITS-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      div_reg       <= DIV_RST;
      frame_div_reg <= DIV_RST;
      overflow_reg  <= 1'b0;
      shift_reg     <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (data_wr & full)
        overflow_reg <= 1'b1;
      else if (wr_en && reg_sel == 2'd1 && bus.din[3])
        overflow_reg <= 1'b0;
      if (wr_en && reg_sel == 2'd2)
        div_reg <= (bus.din[15:0] == 16'd0) ? 16'd1 : bus.din[15:0];
      // The frame keeps its own copy of the divisor so DIV writes only affect later frames.
      if (pop) begin
        frame_div_reg <= div_reg;
        shift_reg     <= mem[rd_ptr_reg];
      end else if (shift_en) begin
        shift_reg <= shift_reg >> 1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  always_ff @(posedge clock) begin
    if (reset || pop)
      parity_reg <= 1'b0;
    else if (state_reg == S_DATA && bit_done)
      parity_reg <= parity_reg ^ shift_reg[0];
  end
`endif

  // tx_next is the line level for the state being entered, so tx stays a clean register output.
  always_comb begin
    state_next   = state_reg;
    timer_next   = (state_reg != S_IDLE && !bit_done) ? timer_reg - 16'd1 : timer_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_en     = 1'b0;
    tx_next      = tx_reg;
    case (state_reg)
      S_IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          state_next = S_START;
          timer_next = div_reg - 16'd1;
          tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_next   = S_DATA;
          timer_next   = frame_div_reg - 16'd1;
          bit_cnt_next = '0;
          tx_next      = shift_reg[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          timer_next = frame_div_reg - 16'd1;
          if (bit_cnt_reg == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
            state_next = S_PARITY;
            tx_next    = parity_reg ^ shift_reg[0];
`else
            state_next = S_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            shift_en     = 1'b1;
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            tx_next      = shift_reg[1];
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_next = S_STOP;
          timer_next = frame_div_reg - 16'd1;
          tx_next    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          state_next = S_IDLE;
          tx_next    = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_comb begin
    status             = '0;
    status[0]          = full;
    status[1]          = empty;
    status[2]          = (state_reg != S_IDLE);
    status[3]          = overflow_reg;
    status[4]          = PARITY_EN;
    status[8 +: CNT_W] = count_reg;
  end

  always_comb begin
    case (reg_sel)
      2'd1:    bus.dout = status;
      2'd2:    bus.dout = {16'b0, div_reg};
      default: bus.dout = 32'd0;
    endcase
  end

  assign tx  = tx_reg;
  assign irq = empty & (state_reg == S_IDLE);
endmodule
